afpm_op_sequencer: RTL

Byte-serial operand sequencer for the logarithmic FP16 multiplier (afpm) core. It collects two 16-bit operands over 8-bit buses, low byte first, and launches the multiplier with a one-cycle start pulse. It waits the core's fixed latency, captures the product, and returns it as two bytes over a ready/valid output. It sits between the tile pins (ui_in/uio_in/uo_out) and the multiplier datapath.

---
 rtl/afpm_pkg.sv | 18 +
 rtl/afpm_lat_timer.sv | 29 ++
 rtl/afpm_op_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/afpm_pkg.sv
// Shared types and constants for the afpm operand sequencer slice.
// Holds the byte/operand widths, the latency ceiling and the sequencer state type.
package afpm_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned OP_W    = 16;
    localparam int unsigned MAX_LAT = 15;

    typedef enum logic [2:0] {
        LOAD_LO,
        LOAD_HI,
        LAUNCH,
        WAIT,
        OUT_LO,
        OUT_HI
    } seq_state_t;

endpackage

// File: rtl/afpm_lat_timer.sv
// 4-bit loadable down-counter that measures the multiplier latency.
// done is high whenever the count has reached zero.
module afpm_lat_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/afpm_op_sequencer.sv
// Byte-serial operand sequencer: gathers two 16-bit operands, launches the
// afpm multiplier, waits its fixed latency and returns the product as two bytes.
module afpm_op_sequencer
    import afpm_pkg::BYTE_W;
    import afpm_pkg::MAX_LAT;
    import afpm_pkg::seq_state_t;
    import afpm_pkg::LOAD_LO;
    import afpm_pkg::LOAD_HI;
    import afpm_pkg::LAUNCH;
    import afpm_pkg::WAIT;
    import afpm_pkg::OUT_LO;
    import afpm_pkg::OUT_HI;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned OP_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] a_byte,
    input  logic [BYTE_W-1:0] b_byte,
    output logic              in_ready,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_start,
    input  logic [OP_W-1:0]   mul_result,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam int unsigned LAT       = (MUL_LATENCY > MAX_LAT) ? MAX_LAT : MUL_LATENCY;
    localparam bit          LAT_ZERO  = (LAT == 0);
    // WAIT lasts LAT cycles, so the timer starts one below the latency.
    localparam logic [3:0]  LAT_LOAD  = LAT_ZERO ? 4'd0 : 4'(LAT - 1);

    seq_state_t      state_q, state_d;
    logic [OP_W-1:0] res_q;
    logic            timer_done;
    logic            lo_we, hi_we, capture, op_done;

    afpm_lat_timer u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (state_q == LAUNCH),
        .load_val (LAT_LOAD),
        .en       (state_q == WAIT),
        .done     (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = (state_q != LOAD_LO);
        mul_start = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = '0;
        lo_we     = 1'b0;
        hi_we     = 1'b0;
        capture   = 1'b0;
        op_done   = 1'b0;

        unique case (state_q)
            LOAD_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lo_we   = 1'b1;
                    state_d = LOAD_HI;
                end
            end
            LOAD_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hi_we   = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                mul_start = 1'b1;
                if (LAT_ZERO) begin
                    capture = 1'b1;
                    state_d = OUT_LO;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timer_done) begin
                    capture = 1'b1;
                    state_d = OUT_LO;
                end
            end
            OUT_LO: begin
                out_valid = 1'b1;
                out_byte  = res_q[BYTE_W-1:0];
                if (out_ready) begin
                    state_d = OUT_HI;
                end
            end
            OUT_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_byte  = res_q[OP_W-1:BYTE_W];
                if (out_ready) begin
                    op_done = 1'b1;
                    state_d = LOAD_LO;
                end
            end
            default: state_d = LOAD_LO;
        endcase

        // Abort wins over every transition and suppresses all side effects.
        if (clr) begin
            state_d   = LOAD_LO;
            mul_start = 1'b0;
            lo_we     = 1'b0;
            hi_we     = 1'b0;
            capture   = 1'b0;
            op_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            res_q    <= '0;
            op_count <= '0;
        end else begin
            if (clr) begin
                mul_a <= '0;
                mul_b <= '0;
                res_q <= '0;
            end else begin
                if (lo_we) begin
                    mul_a[BYTE_W-1:0] <= a_byte;
                    mul_b[BYTE_W-1:0] <= b_byte;
                end
                if (hi_we) begin
                    mul_a[OP_W-1:BYTE_W] <= a_byte;
                    mul_b[OP_W-1:BYTE_W] <= b_byte;
                end
                if (capture) begin
                    res_q <= mul_result;
                end
            end
            if (op_done) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule
